// File: rtl/free_list_multi_if.sv
// rtl/free_list_multi_if.sv - rename/commit-side bus of the multi-lane physical register free list
//
// Purpose: groups the allocate, free, commit and flush signals of free_list_multi.
// Ports (all signals; direction as seen from the free list, i.e. modport slave):
//   alloc_req    in   LANES                 per-lane allocate request (contiguous prefix)
//   alloc_pd     out  LANES*PHYS_REG_BITS   per-lane candidate register, valid when avail > lane
//   avail        out  $clog2(DEPTH)+1       current free count
//   free_valid   in   LANES                 per-lane free strobe (contiguous prefix)
//   free_pd      in   LANES*PHYS_REG_BITS   registers being returned
//   commit_alloc in   LANES                 per-lane "committing instruction held a pd"
//   flush        in   1                     mispredict recovery
//   err          out  1                     sticky underflow/overflow flag
// Modport master is the rename/commit side, slave is the free list.

interface free_list_multi_if #(
   parameter int DEPTH         = 32,
   parameter int PHYS_REG_BITS = 6,
   parameter int LANES         = 2
);
   localparam int PW = $clog2(DEPTH) + 1;

   logic [LANES-1:0]               alloc_req;
   logic [LANES*PHYS_REG_BITS-1:0] alloc_pd;
   logic [PW-1:0]                  avail;
   logic [LANES-1:0]               free_valid;
   logic [LANES*PHYS_REG_BITS-1:0] free_pd;
   logic [LANES-1:0]               commit_alloc;
   logic                           flush;
   logic                           err;

   modport master (
      output alloc_req, free_valid, free_pd, commit_alloc, flush,
      input  alloc_pd, avail, err
   );

   modport slave (
      input  alloc_req, free_valid, free_pd, commit_alloc, flush,
      output alloc_pd, avail, err
   );
endinterface

// File: rtl/free_list_multi.sv
// rtl/free_list_multi.sv - multi-lane circular free list of physical register indices with flush recovery
//
// Purpose: holds free physical register indices in a circular buffer. Rename allocates
// up to LANES registers per cycle from head, commit returns up to LANES registers per
// cycle at tail, and a retired head (rhead) lets a flush give back every speculatively
// allocated register in one cycle.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   bus  free_list_multi_if.slave  (alloc_req/alloc_pd/avail/free_valid/free_pd/
//                                   commit_alloc/flush/err)
// Optional feature: macro FREE_LIST_P0_FILTER_EN squashes free lanes returning
// physical register 0 and compacts the remaining lanes toward tail.

module free_list_multi #(
   parameter int DEPTH         = 32,
   parameter int PHYS_REG_BITS = 6,
   parameter int NUM_ARCH_REGS = 32,
   parameter int LANES         = 2
) (
   input logic               clk,
   input logic               rst,
   free_list_multi_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PHYS_REG_BITS-1:0] mem_q [DEPTH];
   logic [PHYS_REG_BITS-1:0] mem_d [DEPTH];
   logic [PW-1:0]            head_q, head_d;
   logic [PW-1:0]            rhead_q, rhead_d;
   logic [PW-1:0]            tail_q, tail_d;
   logic                     err_q, err_d;

   logic [PW-1:0]            na, nc, nf, room, slot, widx, ridx;
   logic [LANES-1:0]         keep;

   function automatic logic [PW-1:0] popcnt(input logic [LANES-1:0] m);
      logic [PW-1:0] c;
      c = '0;
      for (int i = 0; i < LANES; i++) c = c + PW'(m[i]);
      return c;
   endfunction

   function automatic logic contig(input logic [LANES-1:0] m);
      return ((m & (m + 1'b1)) == '0);
   endfunction

   // Outputs depend on registered state only; freshly freed entries are never bypassed.
   always_comb begin
      bus.alloc_pd = '0;
      ridx = '0;
      for (int i = 0; i < LANES; i++) begin
         ridx = head_q + PW'(i);
         bus.alloc_pd[i*PHYS_REG_BITS +: PHYS_REG_BITS] = mem_q[ridx[AW-1:0]];
      end
   end

   assign bus.avail = tail_q - head_q;
   assign bus.err   = err_q;

   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      rhead_d = rhead_q;
      tail_d  = tail_q;
      err_d   = err_q;
      slot    = '0;
      widx    = '0;

      na = bus.flush ? '0 : popcnt(bus.alloc_req);
      nc = popcnt(bus.commit_alloc);

      rhead_d = rhead_q + nc;

      // Flush rewinds head to the retired head, including this cycle's commits.
      if (bus.flush) begin
         head_d = rhead_q + nc;
      end else if (na <= bus.avail) begin
         head_d = head_q + na;
      end else begin
         err_d = 1'b1;
      end

      keep = bus.free_valid;
`ifdef FREE_LIST_P0_FILTER_EN
      for (int i = 0; i < LANES; i++) begin
         if (bus.free_pd[i*PHYS_REG_BITS +: PHYS_REG_BITS] == '0) keep[i] = 1'b0;
      end
`endif
      nf = popcnt(keep);

      // Overflow is judged against the head after this cycle's allocate/flush.
      room = tail_q - head_d;
      if ({1'b0, room} + {1'b0, nf} > (PW+1)'(DEPTH)) begin
         err_d = 1'b1;
      end else begin
         // Surviving lanes are packed into consecutive slots starting at tail.
         for (int i = 0; i < LANES; i++) begin
            if (keep[i]) begin
               widx = tail_q + slot;
               mem_d[widx[AW-1:0]] = bus.free_pd[i*PHYS_REG_BITS +: PHYS_REG_BITS];
               slot = slot + 1'b1;
            end
         end
         tail_d = tail_q + nf;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= PHYS_REG_BITS'(NUM_ARCH_REGS + i);
         head_q  <= '0;
         rhead_q <= '0;
         tail_q  <= PW'(DEPTH);
         err_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         rhead_q <= rhead_d;
         tail_q  <= tail_d;
         err_q   <= err_d;
      end
   end

   a_contig_masks: assert property (@(posedge clk) disable iff (rst)
      contig(bus.alloc_req) && contig(bus.free_valid) && contig(bus.commit_alloc));

endmodule

// File: tb/tb_free_list_multi.sv
// tb/tb_free_list_multi.sv - directed table-driven bench for free_list_multi (DEPTH=32, LANES=2)

module tb_free_list_multi;
   localparam int DEPTH = 32;
   localparam int PRB   = 6;
   localparam int NAR   = 32;
   localparam int LANES = 2;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   free_list_multi_if #(.DEPTH(DEPTH), .PHYS_REG_BITS(PRB), .LANES(LANES)) bus ();

   free_list_multi #(
      .DEPTH(DEPTH), .PHYS_REG_BITS(PRB), .NUM_ARCH_REGS(NAR), .LANES(LANES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] ar;
      logic [1:0] fv;
      logic [5:0] p0;
      logic [5:0] p1;
      logic [1:0] ca;
      logic       fl;
      int         e_avail;
      int         e_pd0;
      int         e_pd1;
      int         e_err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] ar, input logic [1:0] fv, input logic [5:0] p0,
                      input logic [5:0] p1, input logic [1:0] ca, input logic fl,
                      input int ea, input int e0, input int e1, input int ee);
      vec_t v;
      v.ar = ar; v.fv = fv; v.p0 = p0; v.p1 = p1; v.ca = ca; v.fl = fl;
      v.e_avail = ea; v.e_pd0 = e0; v.e_pd1 = e1; v.e_err = ee;
      tbl.push_back(v);
   endtask

   // Drive one cycle's inputs at the falling edge; outputs reflect pre-edge state afterwards.
   task automatic cyc(input logic [1:0] ar, input logic [1:0] fv, input logic [5:0] p0,
                      input logic [5:0] p1, input logic [1:0] ca, input logic fl);
      @(negedge clk);
      bus.alloc_req    = ar;
      bus.free_valid   = fv;
      bus.free_pd      = {p1, p0};
      bus.commit_alloc = ca;
      bus.flush        = fl;
      #1;
   endtask

   function automatic int pd(input int lane);
      return int'(bus.alloc_pd[lane*PRB +: PRB]);
   endfunction

   // Asynchronous reset pulse while the clock is low, checked before any edge.
   task automatic do_reset(input string tag);
      cyc(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk({tag, "_rst_avail"}, int'(bus.avail), 32);
      chk({tag, "_rst_err"}, int'(bus.err), 0);
      chk({tag, "_rst_pd0"}, pd(0), 32);
      rst = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.alloc_req = '0; bus.free_valid = '0; bus.free_pd = '0;
      bus.commit_alloc = '0; bus.flush = 1'b0;

      // Table: reset state, drain to empty, underflow, same-cycle alloc+free.
      add(2'b00, 2'b00, 0, 0, 2'b00, 0, 32, 32, 33, 0);
      for (int k = 0; k < 16; k++)
         add(2'b11, 2'b00, 0, 0, 2'b00, 0, 32 - 2*k, 32 + 2*k, 33 + 2*k, 0);
      add(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 32, 33, 0);
      add(2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 32, 33, 0);
      add(2'b11, 2'b11, 40, 41, 2'b00, 0, 0, 32, 33, 1);
      add(2'b11, 2'b00, 0, 0, 2'b00, 0, 2, 40, 41, 1);
      add(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 34, 35, 1);

      #12 rst = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].ar, tbl[i].fv, tbl[i].p0, tbl[i].p1, tbl[i].ca, tbl[i].fl);
         chk($sformatf("v%0d_avail", i), int'(bus.avail), tbl[i].e_avail);
         chk($sformatf("v%0d_pd0", i), pd(0), tbl[i].e_pd0);
         chk($sformatf("v%0d_pd1", i), pd(1), tbl[i].e_pd1);
         chk($sformatf("v%0d_err", i), int'(bus.err), tbl[i].e_err);
      end

      // Flush recovery: allocate 6, commit 2, flush back to rhead=2.
      do_reset("fl");
      for (int k = 0; k < 3; k++) cyc(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      cyc(2'b00, 2'b00, 0, 0, 2'b11, 1'b0);
      chk("fl_pre_avail", int'(bus.avail), 26);
      cyc(2'b00, 2'b00, 0, 0, 2'b00, 1'b1);
      cyc(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
      chk("fl_avail", int'(bus.avail), 30);
      chk("fl_pd0", pd(0), 34);
      chk("fl_pd1", pd(1), 35);
      // Flush with one commit and one free in the same cycle; alloc_req ignored.
      cyc(2'b11, 2'b01, 6'd50, 6'd0, 2'b01, 1'b1);
      cyc(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
      chk("fl2_avail", int'(bus.avail), 30);
      chk("fl2_pd0", pd(0), 35);
      chk("fl2_err", int'(bus.err), 0);
      // Walk head to the wrapped tail entry holding 50.
      for (int k = 0; k < 15; k++) begin
         cyc(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
         chk($sformatf("walk%0d_pd0", k), pd(0), 35 + 2*k);
         chk($sformatf("walk%0d_pd1", k), pd(1), (k == 14) ? 50 : 36 + 2*k);
      end
      cyc(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
      chk("walk_avail", int'(bus.avail), 0);
      chk("walk_err", int'(bus.err), 0);

      // Overflow: freeing into a full list drops the write and sets err.
      do_reset("ov");
      cyc(2'b00, 2'b01, 6'd7, 6'd0, 2'b00, 1'b0);
      cyc(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
      chk("ov_err", int'(bus.err), 1);
      chk("ov_avail", int'(bus.avail), 32);
      chk("ov_pd0", pd(0), 32);

      // Free of physical register 0 alongside 45.
      do_reset("p0");
      cyc(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      cyc(2'b00, 2'b11, 6'd0, 6'd45, 2'b00, 1'b0);
      chk("p0_pre_avail", int'(bus.avail), 30);
      cyc(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
`ifdef FREE_LIST_P0_FILTER_EN
      chk("p0_avail", int'(bus.avail), 31);
`else
      chk("p0_avail", int'(bus.avail), 32);
`endif
      for (int k = 0; k < 15; k++) cyc(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      cyc(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
`ifdef FREE_LIST_P0_FILTER_EN
      chk("p0_tail_avail", int'(bus.avail), 1);
      chk("p0_tail_pd0", pd(0), 45);
`else
      chk("p0_tail_avail", int'(bus.avail), 2);
      chk("p0_tail_pd0", pd(0), 0);
      chk("p0_tail_pd1", pd(1), 45);
`endif
      chk("p0_err", int'(bus.err), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/free_list_multi.md
Name: free_list_multi

Overview:
- Parametrised, multi-lane successor to the single-port physical-register free list in the out-of-order core.
- Circular buffer of free physical register indices. Rename allocates up to LANES registers per cycle; commit frees up to LANES old registers per cycle.
- Keeps a retired-head pointer so a branch-mispredict flush restores every speculatively allocated register in one cycle.

Parameters:
- DEPTH, 32, number of entries; power of two.
- PHYS_REG_BITS, 6, width of a physical register index.
- NUM_ARCH_REGS, 32, physical indices 0..NUM_ARCH_REGS-1 are mapped at reset and are not in the list.
- LANES, 2, allocate/free/commit lanes per cycle; 1..4, and LANES <= DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alloc_req  in  LANES  lane i requests one register; must be a contiguous prefix (lanes 0..k-1)
- alloc_pd  out  LANES*PHYS_REG_BITS  lane i candidate = mem[head+i]; valid whenever avail > i
- avail  out  $clog2(DEPTH)+1  current free count (tail-head)
- free_valid  in  LANES  lane i returns free_pd[i] at commit; contiguous prefix
- free_pd  in  LANES*PHYS_REG_BITS  registers being freed
- commit_alloc  in  LANES  lane i's committing instruction held an allocated pd; contiguous prefix
- flush  in  1  mispredict recovery
- err  out  1  sticky underflow/overflow flag

Behaviour:
- Pointers head, rhead, tail are $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty. Wrap is modulo 2*DEPTH; entry index = low bits.
- Reset (asynchronous, takes effect mid-operation without a clock edge):
  - mem[i] = NUM_ARCH_REGS+i
  - head = 0, rhead = 0, tail = DEPTH, so avail = DEPTH
  - err = 0
  - alloc_pd reflects mem[0..LANES-1] immediately after reset.
- Allocate: na = popcount(alloc_req). If na <= avail, head += na at the clock edge. If na > avail, head is unchanged and err is set (underflow). alloc_pd is combinational from current head, zero-latency: rename uses it in the same cycle it asserts alloc_req.
- Free: nf = popcount(free_valid). Lane i writes mem[tail+i] = free_pd[i]; tail += nf. If avail + nf > DEPTH after this cycle's allocate, the write and tail update are dropped and err is set (overflow).
- Commit: rhead += popcount(commit_alloc) every cycle, including flush cycles.
- Flush: head <= rhead + popcount(commit_alloc); alloc_req is ignored that cycle. Free/commit lanes in the same cycle are still applied.
- Same-cycle allocate and free: entries freed this cycle are not allocatable until the next cycle (alloc_pd never bypasses free_pd). avail updates next cycle as avail - na + nf.
- Non-contiguous request masks are illegal; behaviour is undefined and flagged by a simulation assertion.
- err clears only on rst.
- Registered state is limited to mem, the three pointers, and err; avail and alloc_pd are combinational.

Optional Feature:
- Macro FREE_LIST_P0_FILTER_EN.
- Defined: a free lane with free_pd == 0 is squashed, so physical reg 0 (hardwired x0) is never re-entered. Squashed lanes do not count toward nf. Remaining valid lanes are compacted toward tail in lane order.
- Undefined: all free lanes with free_valid=1 are written unconditionally.

Test Plan:
- Reset then idle (DEPTH=32, LANES=2) -> avail=32, alloc_pd lane0=32, lane1=33, err=0.
- alloc_req=2'b11 for 16 cycles -> alloc_pd pairs (32,33) … (62,63), then avail=0. A further alloc_req=2'b01 -> err=1, head unchanged.
- From avail=0: free_valid=2'b11, free_pd=(40,41) with alloc_req=2'b11 in the same cycle -> no allocation (err=1). Next cycle avail=2, alloc_pd=(40,41).
- From reset: allocate 6 registers, commit_alloc=2'b11 once (rhead=2), then flush -> head=2, avail=30, alloc_pd lane0=34.
- Flush with commit_alloc=2'b01 and free_valid=2'b01, free_pd=50 in the same cycle -> head=rhead_old+1, tail advanced by 1, entry 50 appears at the list tail.
- With FREE_LIST_P0_FILTER_EN: free_valid=2'b11, free_pd=(0,45) -> only 45 is written, at mem[tail], and tail += 1. Without the macro: both are written and tail += 2.
